// File: rtl/alu_dispatch_if.sv
// Bus bundle between the ALU issue unit and its surroundings: upstream
// instruction handshake, ALU operand/result wires and downstream result handshake.
interface alu_dispatch_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alucontrol;
    logic [31:0] alu_c;
    logic        alu_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zflag;
    logic        branch_taken;
    logic        illegal;

    // Issue unit side: drives the ALU and both ready/valid responses.
    modport master (
        input  in_valid, instr, rs_val, rt_val, alu_c, alu_z, out_ready,
        output in_ready, alu_a, alu_b, alucontrol, out_valid,
        result, zflag, branch_taken, illegal
    );

    // Environment side: upstream source, the ALU itself and downstream sink.
    modport slave (
        output in_valid, instr, rs_val, rt_val, alu_c, alu_z, out_ready,
        input  in_ready, alu_a, alu_b, alucontrol, out_valid,
        result, zflag, branch_taken, illegal
    );
endinterface

// File: rtl/alu_dispatch.sv
// Multi-cycle ALU issue unit: accepts one instruction, decodes it to an ALU
// control code, holds the operands for ALU_LAT cycles, captures the result
// and offers it downstream. One instruction in flight, no pipelining.
module alu_dispatch #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    alu_dispatch_if.master bus
);

    localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             beq_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic        dec_legal;
    logic        dec_beq;
    logic [31:0] dec_b;
    logic [3:0]  dec_code;
    logic        accept;
    logic        last_cycle;

    // rs/rt/rd/shamt fields are irrelevant here; operands arrive pre-read.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[25:16];

    assign opcode     = bus.instr[31:26];
    assign funct      = bus.instr[5:0];
    assign imm_sext   = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_cycle = (state == ISSUE) && (cnt == CNT_LAST);

    // Decode opcode/funct into legality, operand B selection and ALU code.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dec_legal = 1'b0;
        dec_beq   = 1'b0;
        dec_b     = bus.rt_val;
        dec_code  = 4'b0000;
        case (opcode)
            OP_RTYPE: begin
                dec_legal = 1'b1;
                case (funct)
                    6'h20:   dec_code = 4'b0010;
                    6'h22:   dec_code = 4'b0110;
                    6'h24:   dec_code = 4'b0000;
                    6'h25:   dec_code = 4'b0001;
                    6'h2A:   dec_code = 4'b0111;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                dec_legal = 1'b1;
                dec_b     = imm_sext;
                dec_code  = 4'b0010;
            end
            OP_BEQ: begin
                dec_legal = 1'b1;
                dec_beq   = 1'b1;
                dec_code  = 4'b0110;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = dec_legal ? ISSUE : DONE;
            ISSUE:   if (cnt == CNT_LAST) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Operand registers, settle counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.alucontrol   <= '0;
            bus.result       <= '0;
            bus.zflag        <= 1'b0;
            bus.branch_taken <= 1'b0;
            bus.illegal      <= 1'b0;
            beq_q            <= 1'b0;
            cnt              <= '0;
        end else begin
            if (accept && dec_legal) begin
                bus.alu_a      <= bus.rs_val;
                bus.alu_b      <= dec_b;
                bus.alucontrol <= dec_code;
                beq_q          <= dec_beq;
                cnt            <= '0;
            end
            // Illegal instructions skip the ALU and leave its inputs untouched.
            if (accept && !dec_legal) begin
                bus.result       <= '0;
                bus.zflag        <= 1'b0;
                bus.branch_taken <= 1'b0;
                bus.illegal      <= 1'b1;
            end
            if (state == ISSUE) begin
                cnt <= last_cycle ? '0 : cnt + CNT_W'(1);
            end
            // Branch decision uses the captured result, not the ALU's z flag.
            if (last_cycle) begin
                bus.result       <= bus.alu_c;
                bus.zflag        <= bus.alu_z;
                bus.branch_taken <= beq_q && (bus.alu_c == 32'd0);
                bus.illegal      <= 1'b0;
            end
        end
    end

endmodule
